// File: rtl/craps_game_ctrl.sv
// craps_game_ctrl: synchronizes the roll button, detects the throw on release and
// scores the two dice through the come-out / point game rules.
`default_nettype none

module craps_game_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_MAX   = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       roll_btn,
  input  logic [2:0] die1,
  input  logic [2:0] die2,
  output logic       dice_enable,
  output logic [3:0] sum,
  output logic [3:0] point,
  output logic [1:0] state,
  output logic       win,
  output logic       lose,
  output logic       new_roll,
  output logic       roll_err,
  output logic [6:0] roll_count
);

  typedef enum logic [1:0] {
    COMEOUT = 2'd0,
    POINT   = 2'd1,
    WIN     = 2'd2,
    LOSE    = 2'd3
  } game_state_t;

  game_state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic                   btn_q;
  logic                   strobe;
  logic [3:0]             sum_q, sum_d;
  logic [3:0]             point_q, point_d;
  logic [3:0]             roll_sum;
  logic [6:0]             count_q, count_d, count_inc;
  logic                   new_roll_q, new_roll_d;
  logic                   err_q, err_d;
  logic                   die_bad;

  assign btn_s     = sync_q[SYNC_STAGES-1];
  assign strobe    = btn_q & ~btn_s;
  assign roll_sum  = {1'b0, die1} + {1'b0, die2};
  assign die_bad   = (die1 == 3'd0) || (die1 == 3'd7) || (die2 == 3'd0) || (die2 == 3'd7);
  assign count_inc = (count_q >= 7'(COUNT_MAX)) ? count_q : count_q + 7'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= '0;
      btn_q      <= 1'b0;
      state_q    <= COMEOUT;
      sum_q      <= 4'd0;
      point_q    <= 4'd0;
      count_q    <= 7'd0;
      new_roll_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], roll_btn};
      btn_q      <= btn_s;
      state_q    <= state_d;
      sum_q      <= sum_d;
      point_q    <= point_d;
      count_q    <= count_d;
      new_roll_q <= new_roll_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    point_d    = point_q;
    count_d    = count_q;
    new_roll_d = 1'b0;
    err_d      = 1'b0;
    if (strobe) begin
      if (die_bad) begin
        err_d = 1'b1;
      end else begin
        new_roll_d = 1'b1;
        sum_d      = roll_sum;
        if (state_q == POINT) begin
          count_d = count_inc;
          if (roll_sum == point_q) begin
            state_d = WIN;
          end else if (roll_sum == 4'd7) begin
            state_d = LOSE;
          end
        end else begin
          // A throw after WIN/LOSE is the come-out roll of a fresh game.
          count_d = (state_q == COMEOUT) ? count_inc : 7'd1;
          point_d = 4'd0;
          case (roll_sum)
            4'd7, 4'd11:       state_d = WIN;
            4'd2, 4'd3, 4'd12: state_d = LOSE;
            default: begin
              state_d = POINT;
              point_d = roll_sum;
            end
          endcase
        end
      end
    end
  end

  assign dice_enable = btn_s;
  assign sum         = sum_q;
  assign point       = point_q;
  assign state       = state_q;
  assign win         = (state_q == WIN);
  assign lose        = (state_q == LOSE);
  assign new_roll    = new_roll_q;
  assign roll_err    = err_q;
  assign roll_count  = count_q;

endmodule

`default_nettype wire

// File: doc/craps_game_ctrl.md
CRAPS_GAME_CTRL -- requirements
Module: craps_game_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on roll_btn (legal values 2..4).
REQ-002 SHALL have parameter COUNT_MAX, default 99, the saturation value of roll_count.
REQ-003 SHALL have port clock  input  1  the single system clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port roll_btn  input  1  asynchronous player roll button; held = dice spinning, release = throw.
REQ-006 SHALL have port die1  input  3  value of first dice counter, legal 1..6.
REQ-007 SHALL have port die2  input  3  value of second dice counter, legal 1..6.
REQ-008 SHALL have port dice_enable  output  1  enable to both dice counters; equals the synchronized roll_btn level.
REQ-009 SHALL have port sum  output  4  registered die1+die2 of the last accepted roll.
REQ-010 SHALL have port point  output  4  established point value; 0 when no point.
REQ-011 SHALL have port state  output  2  game state: 0 COMEOUT, 1 POINT, 2 WIN, 3 LOSE.
REQ-012 SHALL have port win  output  1  high while state==WIN.
REQ-013 SHALL have port lose  output  1  high while state==LOSE.
REQ-014 SHALL have port new_roll  output  1  one-cycle pulse when outputs reflect a newly accepted roll.
REQ-015 SHALL have port roll_err  output  1  one-cycle pulse when a throw is rejected for an illegal die value.
REQ-016 SHALL have port roll_count  output  7  accepted rolls in the current game, saturating.

Function
REQ-017 SHALL pass roll_btn through SYNC_STAGES flops; the last stage is btn_s, and dice_enable SHALL equal btn_s.
REQ-018 SHALL register btn_s as btn_q; a throw strobe SHALL be high in any cycle where btn_s==0 and btn_q==1.
REQ-019 SHALL sample die1/die2 on the rising edge ending the strobe cycle and update sum, point, state, roll_count and new_roll on that same edge, so results are visible in the next cycle (latency 1 cycle from strobe).
REQ-020 SHALL reject a throw if either die is 0 or 7: roll_err pulses 1 cycle, and sum, point, state and roll_count stay unchanged, with no new_roll.
REQ-021 SHALL compute sum as a 4-bit zero-extended add (range 2..12); no overflow is possible for legal inputs.
REQ-022 SHALL, in COMEOUT with an accepted throw, go to WIN if sum is 7 or 11, to LOSE if sum is 2, 3 or 12, else go to POINT with point=sum.
REQ-023 SHALL, in POINT with an accepted throw, go to WIN if sum==point, to LOSE if sum==7, else stay in POINT with point unchanged.
REQ-024 SHALL, in WIN or LOSE, treat an accepted throw as the come-out roll of a new game: clear point, set roll_count=1, then apply REQ-022.
REQ-025 SHALL keep point at its value while in WIN/LOSE entered from POINT, and at 0 when WIN/LOSE is entered from COMEOUT.
REQ-026 SHALL increment roll_count on each accepted throw within a game, saturating at COUNT_MAX (no wrap).
REQ-027 SHALL hold all state and outputs between strobes; the state SHALL NOT change without an accepted throw.
REQ-028 SHALL produce at most one strobe per button release; a release shorter than the synchronizer depth still produces exactly one strobe once propagated.

Reset
REQ-029 SHALL, on reset, clear all synchronizer flops and btn_q to 0 and set state=COMEOUT, point=0, sum=0, roll_count=0, win=lose=new_roll=roll_err=0, dice_enable=0.
REQ-030 SHALL have reset take priority over a coincident strobe; that throw is discarded.
REQ-031 SHALL, if roll_btn is held through reset deassertion, produce no strobe until the subsequent release, which is then a normal throw.

Verification
REQ-032 SHALL cover: reset, press/release with die1=3, die2=4 -> one cycle after strobe: sum=7, state=2, win=1, point=0, roll_count=1, new_roll pulse.
REQ-033 SHALL cover: throw 2+2 then 5+3 then 1+3 -> state 1 with point=4, then state 1 with point=4, then state 2, win=1, roll_count=3.
REQ-034 SHALL cover: come-out 6+6 -> state=3, lose=1; next throw 5+6 -> new game, state=2, roll_count=1, point=0.
REQ-035 SHALL cover: point 5 established then throw 3+4 -> state=3, lose=1, point stays 5.
REQ-036 SHALL cover: throw with die1=0, die2=7 -> roll_err pulse, no new_roll, all outputs unchanged; dice_enable tracks roll_btn delayed by SYNC_STAGES cycles.
REQ-037 SHALL cover: reset asserted on the strobe cycle -> outputs at reset values, no new_roll; 120 consecutive throws -> roll_count saturates at 99.
